cm3_matrix_in_stage: RTL and testbench



---
 rtl/cm3_matrix_pkg.sv | 38 +++
 rtl/cm3_matrix_hold_reg.sv | 53 +++++
 rtl/cm3_matrix_in_stage.sv | 136 +++++++++++++
 tb/tb_cm3_matrix_in_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cm3_matrix_pkg.sv
// Shared AHB encodings for the cm3_matrix bus matrix: transfer types, burst
// codes and slave responses used by the input stage, decoder and output stage.
package cm3_matrix_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_INCR   = 3'b001;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_ERROR   = 2'b01;
    localparam logic [1:0] RESP_RETRY   = 2'b10;
    localparam logic [1:0] RESP_SPLIT   = 2'b11;

    // A replayed SEQ beat has lost its burst context, so it restarts as NONSEQ.
    function automatic logic [1:0] replay_trans(input logic [1:0] trans);
        logic [1:0] res;
        if (trans == TRANS_SEQ) begin
            res = TRANS_NONSEQ;
        end else begin
            res = trans;
        end
        return res;
    endfunction

    function automatic logic [2:0] replay_burst(input logic [1:0] trans, input logic [2:0] burst);
        logic [2:0] res;
        if (trans == TRANS_SEQ) begin
            res = BURST_INCR;
        end else begin
            res = burst;
        end
        return res;
    endfunction

endpackage

// File: rtl/cm3_matrix_hold_reg.sv
// Enable-loaded register bank holding one AHB address phase (address and
// control fields) for later replay by the matrix input stage.
module cm3_matrix_hold_reg
    import cm3_matrix_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int USER_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        trans_i,
    input  logic              write_i,
    input  logic [2:0]        size_i,
    input  logic [2:0]        burst_i,
    input  logic [3:0]        prot_i,
    input  logic              lock_i,
    input  logic [USER_W-1:0] auser_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        trans_o,
    output logic              write_o,
    output logic [2:0]        size_o,
    output logic [2:0]        burst_o,
    output logic [3:0]        prot_o,
    output logic              lock_o,
    output logic [USER_W-1:0] auser_o
);

    // Capture the whole address phase whenever the master completes one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_o  <= {ADDR_W{1'b0}};
            trans_o <= TRANS_IDLE;
            write_o <= 1'b0;
            size_o  <= 3'b000;
            burst_o <= 3'b000;
            prot_o  <= 4'b0000;
            lock_o  <= 1'b0;
            auser_o <= {USER_W{1'b0}};
        end else if (load_i) begin
            addr_o  <= addr_i;
            trans_o <= trans_i;
            write_o <= write_i;
            size_o  <= size_i;
            burst_o <= burst_i;
            prot_o  <= prot_i;
            lock_o  <= lock_i;
            auser_o <= auser_i;
        end
    end

endmodule

// File: rtl/cm3_matrix_in_stage.sv
// Slave-port input stage of cm3_matrix: holds an address phase the output
// stage could not take, replays it to the decoder and stalls the master meanwhile.
module cm3_matrix_in_stage
    import cm3_matrix_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int USER_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic [USER_W-1:0] HAUSERS,
    input  logic              HREADYS,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec,
    output logic              sel_in,
    output logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        trans_in,
    output logic              write_in,
    output logic [2:0]        size_in,
    output logic [2:0]        burst_in,
    output logic [3:0]        prot_in,
    output logic              lock_in,
    output logic [USER_W-1:0] auser_in,
    output logic              ready_in,
    output logic              held_tran_in,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS
);

    logic              load_reg_s;
    logic              pend_tran_q;
    logic              pend_tran_d;
    logic [ADDR_W-1:0] h_addr_s;
    logic [1:0]        h_trans_s;
    logic              h_write_s;
    logic [2:0]        h_size_s;
    logic [2:0]        h_burst_s;
    logic [3:0]        h_prot_s;
    logic              h_lock_s;
    logic [USER_W-1:0] h_auser_s;

    // IDLE/BUSY have HTRANS[1] clear, so they never reach the holding register.
    assign load_reg_s = HSELS & HTRANSS[1] & HREADYS;

    cm3_matrix_hold_reg #(
        .ADDR_W (ADDR_W),
        .USER_W (USER_W)
    ) u_hold_reg (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load_i  (load_reg_s),
        .addr_i  (HADDRS),
        .trans_i (HTRANSS),
        .write_i (HWRITES),
        .size_i  (HSIZES),
        .burst_i (HBURSTS),
        .prot_i  (HPROTS),
        .lock_i  (HMASTLOCKS),
        .auser_i (HAUSERS),
        .addr_o  (h_addr_s),
        .trans_o (h_trans_s),
        .write_o (h_write_s),
        .size_o  (h_size_s),
        .burst_o (h_burst_s),
        .prot_o  (h_prot_s),
        .lock_o  (h_lock_s),
        .auser_o (h_auser_s)
    );

    // Pending flag next state: a new hold wins over a simultaneous acceptance.
    always_comb begin
        pend_tran_d = pend_tran_q;
        if (load_reg_s && !active_dec) begin
            pend_tran_d = 1'b1;
        end else if (pend_tran_q && active_dec) begin
            pend_tran_d = 1'b0;
        end else begin
            pend_tran_d = pend_tran_q;
        end
    end

    // Pending flag register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran_q <= 1'b0;
        end else begin
            pend_tran_q <= pend_tran_d;
        end
    end

    // Decoder-side mux and master response; the live path stays combinational.
    always_comb begin
        sel_in       = HSELS;
        addr_in      = HADDRS;
        trans_in     = HTRANSS;
        write_in     = HWRITES;
        size_in      = HSIZES;
        burst_in     = HBURSTS;
        prot_in      = HPROTS;
        lock_in      = HMASTLOCKS;
        auser_in     = HAUSERS;
        held_tran_in = 1'b0;
        HREADYOUTS   = readyout_dec;
        HRESPS       = resp_dec;
        if (pend_tran_q) begin
            sel_in       = 1'b1;
            addr_in      = h_addr_s;
            trans_in     = replay_trans(h_trans_s);
            write_in     = h_write_s;
            size_in      = h_size_s;
            burst_in     = replay_burst(h_trans_s, h_burst_s);
            prot_in      = h_prot_s;
            lock_in      = h_lock_s;
            auser_in     = h_auser_s;
            held_tran_in = 1'b1;
            // The master's data phase belongs to the held transfer, not yet started.
            HREADYOUTS   = 1'b0;
            HRESPS       = RESP_OKAY;
        end else begin
            held_tran_in = 1'b0;
        end
    end

    // No output-side data phase is open while holding, so the decoder may sample.
    assign ready_in = pend_tran_q | HREADYS;

endmodule

// File: tb/tb_cm3_matrix_in_stage.sv
// Self-checking bench for cm3_matrix_in_stage: directed scenarios plus random
// traffic, all compared against a transfer-level reference model every cycle.
module tb_cm3_matrix_in_stage;

    localparam int ADDR_W = 32;
    localparam int USER_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic              HMASTLOCKS;
    logic [USER_W-1:0] HAUSERS;
    logic              HREADYS;
    logic              active_dec;
    logic              readyout_dec;
    logic [1:0]        resp_dec;
    logic              sel_in;
    logic [ADDR_W-1:0] addr_in;
    logic [1:0]        trans_in;
    logic              write_in;
    logic [2:0]        size_in;
    logic [2:0]        burst_in;
    logic [3:0]        prot_in;
    logic              lock_in;
    logic [USER_W-1:0] auser_in;
    logic              ready_in;
    logic              held_tran_in;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;

    cm3_matrix_in_stage #(.ADDR_W(ADDR_W), .USER_W(USER_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS), .HREADYS(HREADYS),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
        .sel_in(sel_in), .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
        .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in), .lock_in(lock_in),
        .auser_in(auser_in), .ready_in(ready_in), .held_tran_in(held_tran_in),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic [31:0] auser;
    } xfer_t;

    // Reference: a queue of transfers waiting for the output stage (depth 0 or 1).
    xfer_t waiting[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic [2:0] burst, input logic rdy,
                         input logic act, input logic rdo, input logic [1:0] rsp);
        HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = wr; HBURSTS = burst;
        HSIZES = 3'd2; HPROTS = 4'b0011; HMASTLOCKS = 1'b0; HAUSERS = addr ^ 32'h5A5A_0000;
        HREADYS = rdy; active_dec = act; readyout_dec = rdo; resp_dec = rsp;
    endtask

    // Compare every output with what the model expects for the current inputs.
    task automatic check_all();
        xfer_t h;
        bit p;
        p = (waiting.size() != 0);
        if (p) begin
            h = waiting[0];
            chk("sel_in", 64'(sel_in), 64'd1);
            chk("addr_in", 64'(addr_in), 64'(h.addr));
            chk("trans_in", 64'(trans_in), (h.trans == 2'b11) ? 64'd2 : 64'(h.trans));
            chk("burst_in", 64'(burst_in), (h.trans == 2'b11) ? 64'd1 : 64'(h.burst));
            chk("write_in", 64'(write_in), 64'(h.write));
            chk("size_in", 64'(size_in), 64'(h.size));
            chk("prot_in", 64'(prot_in), 64'(h.prot));
            chk("lock_in", 64'(lock_in), 64'(h.lock));
            chk("auser_in", 64'(auser_in), 64'(h.auser));
            chk("HREADYOUTS", 64'(HREADYOUTS), 64'd0);
            chk("HRESPS", 64'(HRESPS), 64'd0);
        end else begin
            chk("sel_in", 64'(sel_in), 64'(HSELS));
            chk("addr_in", 64'(addr_in), 64'(HADDRS));
            chk("trans_in", 64'(trans_in), 64'(HTRANSS));
            chk("burst_in", 64'(burst_in), 64'(HBURSTS));
            chk("write_in", 64'(write_in), 64'(HWRITES));
            chk("auser_in", 64'(auser_in), 64'(HAUSERS));
            chk("HREADYOUTS", 64'(HREADYOUTS), 64'(readyout_dec));
            chk("HRESPS", 64'(HRESPS), 64'(resp_dec));
        end
        chk("held_tran_in", 64'(held_tran_in), 64'(p));
        chk("ready_in", 64'(ready_in), 64'(p | HREADYS));
    endtask

    // Apply the transfer-level rules to the inputs present at the clock edge.
    task automatic model_edge();
        xfer_t x;
        bit accepted;
        accepted = HSELS && HTRANSS[1] && HREADYS;
        if (waiting.size() != 0 && active_dec) void'(waiting.pop_front());
        if (accepted && !active_dec) begin
            x.addr = HADDRS; x.trans = HTRANSS; x.write = HWRITES; x.size = HSIZES;
            x.burst = HBURSTS; x.prot = HPROTS; x.lock = HMASTLOCKS; x.auser = HAUSERS;
            waiting.delete();
            waiting.push_back(x);
        end
    endtask

    // Inputs are already driven after a falling edge; check, clock, re-align.
    task automatic cycle();
        #1;
        check_all();
        @(posedge HCLK);
        if (HRESETn) model_edge();
        @(negedge HCLK);
    endtask

    initial begin
        int held_cnt;
        HRESETn = 1'b0;
        drive(1'b1, 32'h0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
        #12;
        chk("rst_held", 64'(held_tran_in), 64'd0);
        chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
        chk("rst_hresp", 64'(HRESPS), 64'd0);
        chk("rst_sel", 64'(sel_in), 64'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Free path
        drive(1'b1, 32'h0000_1000, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00);
        #1;
        chk("free_addr", 64'(addr_in), 64'h1000);
        chk("free_hreadyout0", 64'(HREADYOUTS), 64'd0);
        cycle();
        drive(1'b1, 32'h0000_1004, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
        #1;
        chk("free_held", 64'(held_tran_in), 64'd0);
        chk("free_hreadyout1", 64'(HREADYOUTS), 64'd1);
        cycle();

        // Hold and replay
        drive(1'b1, 32'h0001_0040, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
        cycle();
        held_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0002_0000, 2'b00, 1'b0, 3'b000, 1'b0, (i == 3), 1'b1, 2'b00);
            #1;
            if (held_tran_in) held_cnt++;
            chk("hold_addr", 64'(addr_in), 64'h0001_0040);
            chk("hold_write", 64'(write_in), 64'd1);
            chk("hold_hreadyout", 64'(HREADYOUTS), 64'd0);
            cycle();
        end
        chk("hold_cycles", 64'(held_cnt), 64'd4);
        drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
        #1;
        chk("hold_cleared", 64'(held_tran_in), 64'd0);
        chk("hold_after_rdy", 64'(HREADYOUTS), 64'd1);
        cycle();

        // Held SEQ conversion, then live SEQ untouched
        drive(1'b1, 32'h0000_2004, 2'b11, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 2'b00);
        cycle();
        drive(1'b1, 32'h0000_2008, 2'b11, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 2'b00);
        #1;
        chk("seq_held_trans", 64'(trans_in), 64'd2);
        chk("seq_held_burst", 64'(burst_in), 64'd1);
        cycle();
        drive(1'b1, 32'h0000_2008, 2'b11, 1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 2'b00);
        #1;
        chk("seq_live_trans", 64'(trans_in), 64'd3);
        chk("seq_live_burst", 64'(burst_in), 64'd3);
        cycle();

        // ERROR two-cycle response passthrough
        drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b01);
        #1;
        chk("err1_resp", 64'(HRESPS), 64'd1);
        chk("err1_rdy", 64'(HREADYOUTS), 64'd0);
        cycle();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 2'b01);
        #1;
        chk("err2_resp", 64'(HRESPS), 64'd1);
        chk("err2_rdy", 64'(HREADYOUTS), 64'd1);
        cycle();

        // Reset during hold
        drive(1'b1, 32'h0003_0000, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
        cycle();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
        #1;
        chk("prerst_held", 64'(held_tran_in), 64'd1);
        #2;
        HRESETn = 1'b0;
        waiting.delete();
        #1;
        chk("midrst_held", 64'(held_tran_in), 64'd0);
        chk("midrst_rdy", 64'(HREADYOUTS), 64'd1);
        chk("midrst_resp", 64'(HRESPS), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("postrst_noreplay", 64'(held_tran_in), 64'd0);
            cycle();
        end

        // Random traffic; the master sees HREADY low whenever a transfer waits
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom), 3'($urandom_range(0, 7)),
                  (waiting.size() != 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
            HSIZES = 3'($urandom_range(0, 2));
            HPROTS = 4'($urandom);
            HMASTLOCKS = 1'($urandom);
            HAUSERS = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
